param_seq_detector: RTL and testbench

Serial-bit pattern detector. It is the parametrised successor to the fixed single-pattern detector. The pattern length is set by a parameter and the pattern itself is runtime-loadable. The block adds a selectable overlap/non-overlap mode, a bit-valid qualifier and a saturating match counter. It sits between a serial bit source and the downstream control logic that consumes the one-cycle match pulse w.

---
 rtl/param_seq_detector.sv | 135 +++++++++++++
 tb/tb_param_seq_detector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/param_seq_detector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : param_seq_detector
// Purpose  : Serial-bit pattern detector with a runtime-loadable pattern of
//            PAT_LEN bits, selectable overlapping / non-overlapping detection,
//            a bit-valid qualifier and a saturating match counter.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous, active-low reset
//            a         - serial data bit, accepted when en=1
//            en        - bit-valid qualifier
//            overlap   - 1: overlapping detection, 0: non-overlapping
//            pat_ld    - load strobe for pat_in (clears history)
//            pat_in    - new pattern, MSB is the first bit of the sequence
//            w         - registered one-cycle match pulse
//            match_cnt - saturating count of matches since reset
//            pat_q     - currently active pattern
//            armed     - PAT_LEN valid bits are held in history
// Revision : 1.0 - initial release
// ============================================================================
module param_seq_detector #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 4'b1011,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  input  logic               en,
  input  logic               overlap,
  input  logic               pat_ld,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               w,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [PAT_LEN-1:0] pat_q,
  output logic               armed
);

  // Fill counter must hold the value PAT_LEN itself.
  localparam int                 FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               w_q, w_d;
  logic               armed_q, armed_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  // Candidate history/fill if the current bit is accepted; the oldest bit
  // ends up at the MSB so it lines up with the pattern MSB.
  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], a};
    fill_inc   = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    match      = (hist_shift == pat_q) && (fill_inc == FILL_MAX);
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    w_d     = 1'b0;

    if (pat_ld) begin
      // Load takes priority over a coincident valid bit, which is dropped.
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_EMPTY;
    end else if (en) begin
      if (match) begin
        w_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (overlap) begin
          hist_d  = hist_shift;
          fill_d  = fill_inc;
          state_d = ST_ARMED;
        end else begin
          // Non-overlapping: the next match needs PAT_LEN fresh bits.
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_EMPTY;
        end
      end else begin
        hist_d  = hist_shift;
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_MAX) ? ST_ARMED : ST_FILLING;
      end
    end

    armed_d = (state_d == ST_ARMED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_DEFAULT;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      armed_q <= armed_d;
    end
  end

  assign w         = w_q;
  assign match_cnt = cnt_q;
  assign armed     = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_param_seq_detector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_param_seq_detector
// Purpose  : Directed, table-driven bench for param_seq_detector. A second
//            instance with a 3-bit counter exercises counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_seq_detector;

  localparam logic [3:0] PB = 4'b1011;
  localparam logic [3:0] P6 = 4'b0110;
  localparam logic [3:0] PF = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, en, overlap, pat_ld;
  logic [3:0] pat_in;

  logic       w1, armed1;
  logic [7:0] cnt1;
  logic [3:0] pat1;
  logic       w2, armed2;
  logic [2:0] cnt2;
  logic [3:0] pat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_seq_detector #(.PAT_LEN(4), .PAT_DEFAULT(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .en(en), .overlap(overlap),
    .pat_ld(pat_ld), .pat_in(pat_in),
    .w(w1), .match_cnt(cnt1), .pat_q(pat1), .armed(armed1)
  );

  param_seq_detector #(.PAT_LEN(4), .PAT_DEFAULT(4'b1011), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .en(en), .overlap(overlap),
    .pat_ld(pat_ld), .pat_in(pat_in),
    .w(w2), .match_cnt(cnt2), .pat_q(pat2), .armed(armed2)
  );

  typedef struct {
    logic       en;
    logic       a;
    logic       ov;
    logic       ld;
    logic [3:0] pin;
    logic       w;
    logic [7:0] cnt;
    logic       armed;
    logic [3:0] pat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic d, input logic ov, input logic ld,
                     input logic [3:0] pin, input logic ew, input logic [7:0] ec,
                     input logic ea, input logic [3:0] ep);
    vec_t v;
    v.en = e; v.a = d; v.ov = ov; v.ld = ld; v.pin = pin;
    v.w = ew; v.cnt = ec; v.armed = ea; v.pat = ep;
    vecs.push_back(v);
  endtask

  // Drive inputs just after an edge, clock once, sample 1 ns after the edge.
  task automatic step(input logic e, input logic d, input logic ov,
                      input logic ld, input logic [3:0] pin);
    en = e; a = d; overlap = ov; pat_ld = ld; pat_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic add_t2(input logic [7:0] c0);
    add(1, 1, 1, 0, 4'h0, 0, c0,      0, PB);
    add(1, 0, 1, 0, 4'h0, 0, c0,      0, PB);
    add(1, 1, 1, 0, 4'h0, 0, c0,      0, PB);
    add(1, 1, 1, 0, 4'h0, 1, c0 + 1,  1, PB);
    add(1, 0, 1, 0, 4'h0, 0, c0 + 1,  1, PB);
    add(1, 1, 1, 0, 4'h0, 0, c0 + 1,  1, PB);
    add(1, 1, 1, 0, 4'h0, 1, c0 + 2,  1, PB);
  endtask

  initial begin
    // Overlapping stream 1011011: matches after bits 4 and 7.
    add_t2(8'd0);
    add(0, 0, 0, 1, PB, 0, 8'd2, 0, PB);
    // Non-overlapping: one match, then 3 bits leave it filling; a 4th arms it.
    add(1, 1, 0, 0, 4'h0, 0, 8'd2, 0, PB);
    add(1, 0, 0, 0, 4'h0, 0, 8'd2, 0, PB);
    add(1, 1, 0, 0, 4'h0, 0, 8'd2, 0, PB);
    add(1, 1, 0, 0, 4'h0, 1, 8'd3, 0, PB);
    add(1, 0, 0, 0, 4'h0, 0, 8'd3, 0, PB);
    add(1, 1, 0, 0, 4'h0, 0, 8'd3, 0, PB);
    add(1, 1, 0, 0, 4'h0, 0, 8'd3, 0, PB);
    add(1, 0, 0, 0, 4'h0, 0, 8'd3, 1, PB);
    add(0, 0, 1, 1, PB, 0, 8'd3, 0, PB);
    // Gapped bits with misleading data on en=0 cycles.
    add(1, 1, 1, 0, 4'h0, 0, 8'd3, 0, PB);
    add(0, 0, 1, 0, 4'h0, 0, 8'd3, 0, PB);
    add(1, 0, 1, 0, 4'h0, 0, 8'd3, 0, PB);
    add(0, 1, 1, 0, 4'h0, 0, 8'd3, 0, PB);
    add(1, 1, 1, 0, 4'h0, 0, 8'd3, 0, PB);
    add(0, 0, 1, 0, 4'h0, 0, 8'd3, 0, PB);
    add(1, 1, 1, 0, 4'h0, 1, 8'd4, 1, PB);
    add(0, 1, 1, 0, 4'h0, 0, 8'd4, 1, PB);
    // Pattern load on the same edge as a valid bit: the bit is dropped.
    add(1, 1, 1, 1, P6, 0, 8'd4, 0, P6);
    add(1, 0, 1, 0, 4'h0, 0, 8'd4, 0, P6);
    add(1, 1, 1, 0, 4'h0, 0, 8'd4, 0, P6);
    add(1, 1, 1, 0, 4'h0, 0, 8'd4, 0, P6);
    add(1, 0, 1, 0, 4'h0, 1, 8'd5, 1, P6);
    add(1, 1, 1, 0, 4'h0, 0, 8'd5, 1, P6);
    add(1, 0, 1, 0, 4'h0, 0, 8'd5, 1, P6);
    add(1, 1, 1, 0, 4'h0, 0, 8'd5, 1, P6);
    add(1, 1, 1, 0, 4'h0, 0, 8'd5, 1, P6);
    add(0, 0, 1, 1, PB, 0, 8'd5, 0, PB);
    // Overlapping stream again, ending on a w=1 cycle before async reset.
    add_t2(8'd5);

    rst = 1'b0; a = 1'b0; en = 1'b0; overlap = 1'b1; pat_ld = 1'b0; pat_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w",     32'(w1),     32'd0);
    chk("reset_cnt",   32'(cnt1),   32'd0);
    chk("reset_pat",   32'(pat1),   32'(PB));
    chk("reset_armed", 32'(armed1), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].a, vecs[i].ov, vecs[i].ld, vecs[i].pin);
      chk($sformatf("vec%0d_w", i),     32'(w1),     32'(vecs[i].w));
      chk($sformatf("vec%0d_cnt", i),   32'(cnt1),   32'(vecs[i].cnt));
      chk($sformatf("vec%0d_armed", i), 32'(armed1), 32'(vecs[i].armed));
      chk($sformatf("vec%0d_pat", i),   32'(pat1),   32'(vecs[i].pat));
    end

    // Asynchronous reset mid-cycle, right after a w=1 cycle.
    #2 rst = 1'b0;
    #1;
    chk("async_w",     32'(w1),     32'd0);
    chk("async_cnt",   32'(cnt1),   32'd0);
    chk("async_armed", 32'(armed1), 32'd0);
    chk("async_pat",   32'(pat1),   32'(PB));
    // Inputs are ignored while reset is held.
    step(1, 1, 1, 1, 4'h0);
    chk("hold_pat",   32'(pat1),   32'(PB));
    chk("hold_cnt",   32'(cnt1),   32'd0);
    chk("hold_armed", 32'(armed1), 32'd0);
    rst = 1'b1;
    // Three accepted bits are not enough to arm.
    step(1, 1, 1, 0, 4'h0);
    chk("post_rst_b1_armed", 32'(armed1), 32'd0);
    step(1, 0, 1, 0, 4'h0);
    chk("post_rst_b2_armed", 32'(armed1), 32'd0);
    step(1, 1, 1, 0, 4'h0);
    chk("post_rst_b3_armed", 32'(armed1), 32'd0);
    chk("post_rst_b3_w",     32'(w1),     32'd0);

    // Saturation: pattern 1111, a held high, overlapping.
    step(0, 1, 1, 1, PF);
    chk("sat_ld_pat", 32'(pat2), 32'(PF));
    chk("sat_ld_cnt", 32'(cnt2), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      int exp_c;
      exp_c = (k < 4) ? 0 : k - 3;
      step(1, 1, 1, 0, 4'h0);
      chk($sformatf("sat%0d_w", k),      32'(w2),   (k >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("sat%0d_cnt3", k),   32'(cnt2), 32'((exp_c > 7) ? 7 : exp_c));
      chk($sformatf("sat%0d_cnt8", k),   32'(cnt1), 32'(exp_c));
      chk($sformatf("sat%0d_armed", k),  32'(armed2), (k >= 4) ? 32'd1 : 32'd0);
    end
    // en=0 drops w immediately even while armed on a matching history.
    step(0, 1, 1, 0, 4'h0);
    chk("sat_gap_w",   32'(w2),   32'd0);
    chk("sat_gap_cnt", 32'(cnt2), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
